// File: rtl/oc8051_iram_bist_ctrl.sv
// March C- self-test controller and port mux for the 8051 internal RAM.
// Define OC8051_BIST_DIAG_EN to capture the first failing address and data.
module oc8051_iram_bist_ctrl #(
    parameter int         ADDR_LAST = 15,
    parameter logic [7:0] PAT       = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_rd_addr,
    input  logic       cpu_rd_en,
    input  logic [7:0] cpu_wr_addr,
    input  logic [7:0] cpu_wr_data,
    input  logic       cpu_wr,
    output logic [7:0] cpu_rd_data,
    output logic       cpu_stall,
    output logic [7:0] ram_rd_addr,
    output logic       ram_rd_en,
    output logic [7:0] ram_wr_addr,
    output logic [7:0] ram_wr_data,
    output logic       ram_wr,
    output logic       ram_wr_en,
    input  logic [7:0] ram_rd_data,
    input  logic       bist_start,
    output logic       bist_busy,
    output logic       bist_done,
    output logic       bist_fail,
    output logic [7:0] bist_fail_addr,
    output logic [7:0] bist_fail_data
);

    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, M5, DONE} state_t;

    localparam logic [7:0] LAST = 8'(ADDR_LAST);

    state_t     state;
    logic [7:0] addr;
    logic       phase_b;
    logic       busy;
    logic       done;
    logic       fail;
    state_t     nxt;
    logic       elem_end;

    function automatic logic [7:0] expect_data(input state_t s);
        case (s)
            M2, M4:  expect_data = ~PAT;
            default: expect_data = PAT;
        endcase
    endfunction

    function automatic logic [7:0] write_data(input state_t s);
        case (s)
            M1, M3:  write_data = ~PAT;
            default: write_data = PAT;
        endcase
    endfunction

    function automatic state_t next_elem(input state_t s);
        case (s)
            M0:      next_elem = M1;
            M1:      next_elem = M2;
            M2:      next_elem = M3;
            M3:      next_elem = M4;
            M4:      next_elem = M5;
            default: next_elem = DONE;
        endcase
    endfunction

    function automatic logic is_desc(input state_t s);
        is_desc = (s == M3) || (s == M4);
    endfunction

    assign nxt      = next_elem(state);
    assign elem_end = is_desc(state) ? (addr == 8'd0) : (addr == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            addr    <= '0;
            phase_b <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
`ifdef OC8051_BIST_DIAG_EN
            bist_fail_addr <= '0;
            bist_fail_data <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bist_start) begin
                        state   <= M0;
                        addr    <= '0;
                        phase_b <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        fail    <= 1'b0;
`ifdef OC8051_BIST_DIAG_EN
                        bist_fail_addr <= '0;
                        bist_fail_data <= '0;
`endif
                    end
                end
                M0: begin
                    if (addr == LAST) begin
                        state <= M1;
                        addr  <= '0;
                    end else begin
                        addr <= addr + 8'd1;
                    end
                end
                default: begin
                    // Phase A issues the read; phase B compares, writes back and steps.
                    if (!phase_b) begin
                        phase_b <= 1'b1;
                    end else begin
                        phase_b <= 1'b0;
                        if (ram_rd_data != expect_data(state)) begin
                            fail <= 1'b1;
`ifdef OC8051_BIST_DIAG_EN
                            if (!fail) begin
                                bist_fail_addr <= addr;
                                bist_fail_data <= ram_rd_data;
                            end
`endif
                        end
                        if (elem_end) begin
                            state <= nxt;
                            addr  <= is_desc(nxt) ? LAST : 8'd0;
                            if (nxt == DONE) begin
                                busy <= 1'b0;
                                done <= 1'b1;
                            end
                        end else begin
                            addr <= is_desc(state) ? addr - 8'd1 : addr + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifndef OC8051_BIST_DIAG_EN
    assign bist_fail_addr = 8'h00;
    assign bist_fail_data = 8'h00;
`endif

    // The test owns both RAM ports whenever busy; otherwise the CPU passes straight through.
    always_comb begin
        ram_rd_addr = cpu_rd_addr;
        ram_rd_en   = cpu_rd_en;
        ram_wr_addr = cpu_wr_addr;
        ram_wr_data = cpu_wr_data;
        ram_wr      = cpu_wr;
        if (busy) begin
            ram_rd_addr = addr;
            ram_wr_addr = addr;
            ram_wr_data = write_data(state);
            ram_rd_en   = (state != M0) && !phase_b;
            ram_wr      = (state == M0) || (phase_b && (state != M5));
        end
    end

    assign ram_wr_en   = ram_wr;
    assign cpu_rd_data = ram_rd_data;
    assign cpu_stall   = busy;
    assign bist_busy   = busy;
    assign bist_done   = done;
    assign bist_fail   = fail;

endmodule
